// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if: control inputs and match status outputs of the pong match sequencer
interface pong_match_ctrl_if;
  logic       enable;
  logic       start;
  logic       frame_tick;
  logic       p1s;
  logic       p2s;
  logic       ball_run;
  logic       ball_rst;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state_o;
  modport master (
    output enable, start, frame_tick, p1s, p2s,
    input  ball_run, ball_rst, p1_score, p2_score, winner, state_o
  );
  modport slave (
    input  enable, start, frame_tick, p1s, p2s,
    output ball_run, ball_rst, p1_score, p2_score, winner, state_o
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer gating the ball, counting goals and detecting game over
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int CNT_W        = 7
) (
  input logic             clk,
  input logic             reset,
  pong_match_ctrl_if.slave pm
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       p1_score, p2_score, p1_n, p2_n;
  logic [1:0]       winner, winner_n;
  logic             ball_run, ball_rst;
  logic             start_q, p1s_q, p2s_q;
  logic             start_e, p1_e, p2_e, en;
  assign start_e = pm.start & ~start_q;
  assign p1_e    = pm.p1s & ~p1s_q;
  assign p2_e    = pm.p2s & ~p2s_q;
  assign en      = pm.enable;
  assign pm.ball_run = ball_run;
  assign pm.ball_rst = ball_rst;
  assign pm.p1_score = p1_score;
  assign pm.p2_score = p2_score;
  assign pm.winner   = winner;
  assign pm.state_o  = state;
  // next-state, frame counter and score update; everything holds while enable is low
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    p1_n     = p1_score;
    p2_n     = p2_score;
    winner_n = winner;
    case (state)
      IDLE: if (en && start_e) begin
        state_n = SERVE;
        cnt_n   = '0;
      end
      SERVE: if (en && pm.frame_tick) begin
        state_n = (cnt == SERVE_LAST) ? PLAY : SERVE;
        cnt_n   = (cnt == SERVE_LAST) ? '0 : cnt + 1'b1;
      end
      PLAY: if (en && (p1_e || p2_e)) begin
        state_n = POINT;
        cnt_n   = '0;
        p1_n    = (p1_e && !p2_e && p1_score != WIN) ? p1_score + 4'd1 : p1_score;
        p2_n    = (p2_e && !p1_e && p2_score != WIN) ? p2_score + 4'd1 : p2_score;
      end
      POINT: if (en && pm.frame_tick) begin
        cnt_n = (cnt == POINT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == POINT_LAST) begin
          state_n  = (p1_score == WIN || p2_score == WIN) ? OVER : SERVE;
          winner_n = (p1_score == WIN) ? 2'b01 : (p2_score == WIN) ? 2'b10 : 2'b00;
        end
      end
      OVER: if (en && start_e) begin
        state_n  = IDLE;
        cnt_n    = '0;
        p1_n     = '0;
        p2_n     = '0;
        winner_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  // state registers, with ball controls decoded from the next state so they align with state_o
  always_ff @(posedge clk) begin
    start_q <= pm.start;
    p1s_q   <= pm.p1s;
    p2s_q   <= pm.p2s;
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      p1_score <= '0;
      p2_score <= '0;
      winner   <= '0;
      ball_run <= 1'b0;
      ball_rst <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      p1_score <= p1_n;
      p2_score <= p2_n;
      winner   <= winner_n;
      ball_run <= en & (state_n == PLAY);
      ball_rst <= state_n != PLAY;
    end
  end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed scoreboard bench for the pong match sequencer
module tb_pong_match_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [14:0] q[$];
  string       nq[$];
  pong_match_ctrl_if pm ();
  pong_match_ctrl dut (.clk(clk), .reset(reset), .pm(pm));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(int n);
    repeat (n) begin
      pm.frame_tick = 1'b1;
      step();
      pm.frame_tick = 1'b0;
      step();
    end
  endtask
  task automatic expect_st(string nm, logic [2:0] st, logic [3:0] a, logic [3:0] b,
                           logic [1:0] w, logic run, logic rst);
    q.push_back({st, a, b, w, run, rst});
    nq.push_back(nm);
  endtask
  // monitor: compare every queued expectation against the outputs at the falling edge
  always @(negedge clk) begin
    logic [14:0] e, g;
    string nm;
    while (q.size() > 0) begin
      e  = q.pop_front();
      nm = nq.pop_front();
      g  = {pm.state_o, pm.p1_score, pm.p2_score, pm.winner, pm.ball_run, pm.ball_rst};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d p1=%0d p2=%0d w=%0d run=%0b rst=%0b, expected st=%0d p1=%0d p2=%0d w=%0d run=%0b rst=%0b",
                 nm, g[14:12], g[11:8], g[7:4], g[3:2], g[1], g[0],
                 e[14:12], e[11:8], e[7:4], e[3:2], e[1], e[0]);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    pm.enable = 1'b1;
    pm.start = 1'b0;
    pm.frame_tick = 1'b0;
    pm.p1s = 1'b0;
    pm.p2s = 1'b0;
    step();
    step();
    expect_st("reset", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    step();
    expect_st("idle_hold", 0, 0, 0, 0, 0, 1);
    pm.start = 1'b1;
    step();
    expect_st("start_serve", 1, 0, 0, 0, 0, 1);
    pm.start = 1'b0;
    pm.p1s = 1'b1;
    step();
    expect_st("edge_in_serve_ignored", 1, 0, 0, 0, 0, 1);
    pm.p1s = 1'b0;
    ticks(59);
    expect_st("serve_59", 1, 0, 0, 0, 0, 1);
    ticks(1);
    expect_st("serve_to_play", 2, 0, 0, 0, 1, 0);
    pm.p2s = 1'b1;
    step();
    expect_st("p2_goal", 3, 0, 1, 0, 0, 1);
    pm.p2s = 1'b0;
    ticks(89);
    expect_st("point_89", 3, 0, 1, 0, 0, 1);
    ticks(1);
    expect_st("point_to_serve", 1, 0, 1, 0, 0, 1);
    ticks(60);
    expect_st("serve_play_2", 2, 0, 1, 0, 1, 0);
    pm.start = 1'b1;
    step();
    expect_st("start_in_play_ignored", 2, 0, 1, 0, 1, 0);
    pm.start = 1'b0;
    pm.p1s = 1'b1;
    pm.p2s = 1'b1;
    step();
    expect_st("both_goal_replay", 3, 0, 1, 0, 0, 1);
    pm.p1s = 1'b0;
    pm.p2s = 1'b0;
    ticks(90);
    expect_st("replay_serve", 1, 0, 1, 0, 0, 1);
    ticks(60);
    for (int i = 1; i <= 9; i++) begin
      expect_st("rally_play", 2, 4'(i - 1), 1, 0, 1, 0);
      pm.p1s = 1'b1;
      step();
      expect_st("p1_goal", 3, 4'(i), 1, 0, 0, 1);
      pm.p1s = 1'b0;
      ticks(90);
      if (i < 9) begin
        expect_st("rally_serve", 1, 4'(i), 1, 0, 0, 1);
        ticks(60);
      end
    end
    expect_st("game_over", 4, 9, 1, 1, 0, 1);
    pm.p1s = 1'b1;
    step();
    pm.p1s = 1'b0;
    step();
    expect_st("over_holds_score", 4, 9, 1, 1, 0, 1);
    pm.start = 1'b1;
    step();
    expect_st("over_to_idle", 0, 0, 0, 0, 0, 1);
    pm.start = 1'b0;
    step();
    pm.start = 1'b1;
    step();
    pm.start = 1'b0;
    ticks(30);
    pm.enable = 1'b0;
    ticks(100);
    expect_st("frozen_serve", 1, 0, 0, 0, 0, 1);
    pm.enable = 1'b1;
    ticks(29);
    expect_st("resume_serve_59", 1, 0, 0, 0, 0, 1);
    ticks(1);
    expect_st("resume_to_play", 2, 0, 0, 0, 1, 0);
    pm.enable = 1'b0;
    step();
    expect_st("disable_play", 2, 0, 0, 0, 0, 0);
    pm.enable = 1'b1;
    step();
    expect_st("reenable_play", 2, 0, 0, 0, 1, 0);
    pm.p1s = 1'b1;
    reset = 1'b1;
    step();
    expect_st("reset_mid_play", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    step();
    pm.start = 1'b1;
    step();
    expect_st("restart_serve", 1, 0, 0, 0, 0, 1);
    pm.start = 1'b0;
    ticks(60);
    expect_st("held_p1s_play", 2, 0, 0, 0, 1, 0);
    step();
    expect_st("held_p1s_no_goal", 2, 0, 0, 0, 1, 0);
    pm.p1s = 1'b0;
    step();
    pm.p1s = 1'b1;
    step();
    expect_st("fresh_p1_goal", 3, 1, 0, 0, 0, 1);
    pm.p1s = 1'b0;
    step();
    step();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
